// File: rtl/pcm_spi_packer_if.sv
// pcm_spi_packer_if: PCM sample input and SPI byte-output signals of the
// PCM-to-SPI packer, grouped for port connection.
// master: sample source / SPI slave side.  slave: the packer itself.
interface pcm_spi_packer_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] pcm_data;
  logic                    pcm_channel;
  logic                    pcm_valid;
  logic                    spi_busy;
  logic [7:0]              spi_tx_data;
  logic                    spi_tx_valid;

  modport master (
    output pcm_data, pcm_channel, pcm_valid, spi_busy,
    input  spi_tx_data, spi_tx_valid
  );

  modport slave (
    input  pcm_data, pcm_channel, pcm_valid, spi_busy,
    output spi_tx_data, spi_tx_valid
  );
endinterface

// File: rtl/pcm_spi_packer.sv
// pcm_spi_packer: splits PCM samples into bytes (LSB first), buffers them in a
// byte FIFO and hands one byte to an SPI slave per rising edge of its
// asynchronous spi_busy request line.  Whole samples are dropped when they
// cannot be stored completely; in stereo a left sample is only taken when the
// whole L/R frame fits, so the stream never holds half a frame.
// Optional feature macro: PCM_PACKER_OVF_CNT_EN enables the 16-bit saturating
// dropped-sample counter on ovf_count; without it ovf_count is tied to zero.
module pcm_spi_packer #(
  parameter int         SAMPLE_WIDTH  = 16,
  parameter int         CHANNELS      = 1,
  parameter int         DEPTH         = 4096,
  parameter logic [7:0] UNDERRUN_BYTE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pcm_spi_packer_if.slave        bus,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   underrun,
  output logic [15:0]            ovf_count
);

  localparam int              BYTES      = SAMPLE_WIDTH / 8;
  localparam int              AW         = $clog2(DEPTH);
  localparam int              LW         = AW + 1;
  localparam logic [LW-1:0]   DEPTH_L    = LW'(DEPTH);
  localparam logic [LW-1:0]   NEED_ONE   = LW'(BYTES);
  localparam logic [LW-1:0]   NEED_FRAME = LW'(CHANNELS * BYTES);
  localparam logic [2:0]      LAST_IDX   = 3'(BYTES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} wr_state_e;

  // write side
  wr_state_e               state_q;
  logic [SAMPLE_WIDTH-1:0] shreg_q;
  logic [2:0]              bidx_q;
  logic                    pend_vld_q;
  logic [SAMPLE_WIDTH-1:0] pend_data_q;
  logic [AW-1:0]           wr_ptr_q;
  logic                    last_l_q;
  logic                    last_acc_q;

  // storage and read side
  logic [7:0]              mem_q [DEPTH];
  logic [7:0]              rd_data_q;
  logic [AW-1:0]           rd_ptr_q;
  logic                    pop_q;
  logic [LW-1:0]           level_q, level_d;
  logic [LW-1:0]           rsv_q, rsv_d;
  logic                    sync1_q, sync2_q, sync3_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    underrun_q;
  logic                    overflow_q;

  logic [LW-1:0]           free_s, need_s;
  logic                    align_ok_s, slot_ok_s, accept_s, drop_s;
  logic                    req_s, pop_s, push_s, last_byte_s;

  // Acceptance, drop and FIFO bookkeeping decisions for this cycle.
  // rsv_q counts bytes stored plus bytes committed by accepted samples not yet
  // written, so the space check already covers the sample in flight and the
  // pending slot.
  always_comb begin
    req_s       = sync2_q & ~sync3_q;
    pop_s       = req_s & (level_q != '0);
    push_s      = (state_q == WRITE);
    last_byte_s = push_s & (bidx_q == LAST_IDX);
    free_s      = DEPTH_L - rsv_q;
    if ((CHANNELS == 2) && !bus.pcm_channel) begin
      need_s = NEED_FRAME;
    end else begin
      need_s = NEED_ONE;
    end
    if (CHANNELS == 2) begin
      if (bus.pcm_channel) begin
        align_ok_s = last_l_q & last_acc_q;
      end else begin
        align_ok_s = ~last_l_q;
      end
    end else begin
      align_ok_s = 1'b1;
    end
    if (state_q == IDLE) begin
      slot_ok_s = 1'b1;
    end else begin
      slot_ok_s = ~pend_vld_q | last_byte_s;
    end
    accept_s = bus.pcm_valid & align_ok_s & slot_ok_s & (free_s >= need_s);
    drop_s   = bus.pcm_valid & ~accept_s;
    level_d  = level_q + LW'(push_s) - LW'(pop_s);
    rsv_d    = rsv_q + (accept_s ? NEED_ONE : '0) - LW'(pop_s);
  end

  // Write FSM: serialises the current sample into the FIFO one byte per clock
  // and chains straight into the pending (or a freshly arriving) sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bidx_q      <= 3'd0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      wr_ptr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q <= WRITE;
            shreg_q <= bus.pcm_data;
            bidx_q  <= 3'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        WRITE: begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          if (last_byte_s) begin
            bidx_q <= 3'd0;
            if (pend_vld_q) begin
              state_q     <= WRITE;
              shreg_q     <= pend_data_q;
              pend_vld_q  <= accept_s;
              pend_data_q <= bus.pcm_data;
            end else if (accept_s) begin
              state_q <= WRITE;
              shreg_q <= bus.pcm_data;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            bidx_q  <= bidx_q + 3'd1;
            shreg_q <= shreg_q >> 8;
            if (accept_s) begin
              pend_vld_q  <= 1'b1;
              pend_data_q <= bus.pcm_data;
            end else begin
              pend_vld_q  <= pend_vld_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Byte RAM write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= shreg_q[7:0];
    end
  end

  // Registered RAM read port, loaded on every pop.
  always_ff @(posedge clk) begin
    if (pop_s) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  // Track the channel and fate of the last offered sample for L/R alignment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_l_q   <= 1'b0;
      last_acc_q <= 1'b0;
    end else if (bus.pcm_valid) begin
      last_l_q   <= ~bus.pcm_channel;
      last_acc_q <= accept_s;
    end else begin
      last_l_q   <= last_l_q;
      last_acc_q <= last_acc_q;
    end
  end

  // spi_busy synchroniser, edge register, read pointer and fill counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      rd_ptr_q <= '0;
      pop_q    <= 1'b0;
      level_q  <= '0;
      rsv_q    <= '0;
    end else begin
      sync1_q  <= bus.spi_busy;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      rd_ptr_q <= rd_ptr_q + AW'(pop_s);
      pop_q    <= pop_s;
      level_q  <= level_d;
      rsv_q    <= rsv_d;
    end
  end

  // SPI output register: popped byte one clock after the RAM read, or the
  // underrun byte straight away when the request finds the FIFO empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else if (pop_q) begin
      tx_data_q  <= rd_data_q;
      tx_valid_q <= 1'b1;
      underrun_q <= 1'b0;
    end else if (req_s && !pop_s) begin
      tx_data_q  <= UNDERRUN_BYTE;
      tx_valid_q <= 1'b1;
      underrun_q <= 1'b1;
    end else begin
      tx_data_q  <= tx_data_q;
      tx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end
  end

  // Sticky overflow flag; a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop_s) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q;
    end
  end

`ifdef PCM_PACKER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  // Saturating dropped-sample counter; clear plus drop in one cycle gives 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt_q <= 16'h0000;
    end else if (ovf_clr) begin
      ovf_cnt_q <= drop_s ? 16'h0001 : 16'h0000;
    end else if (drop_s && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'h0001;
    end else begin
      ovf_cnt_q <= ovf_cnt_q;
    end
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 16'h0000;
`endif

  assign bus.spi_tx_data  = tx_data_q;
  assign bus.spi_tx_valid = tx_valid_q;
  assign fifo_level       = level_q;
  assign overflow         = overflow_q;
  assign underrun         = underrun_q;

endmodule

// File: doc/pcm_spi_packer.md
PCM_SPI_PACKER -- requirements
Module: pcm_spi_packer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, 16, PCM sample width in bits (8, 16, 24 or 32).
REQ-002 SHALL have parameter CHANNELS, 1, channel count per frame (1 mono, 2 stereo L then R).
REQ-003 SHALL have parameter DEPTH, 4096, FIFO depth in bytes (power of two, at least 16).
REQ-004 SHALL have parameter UNDERRUN_BYTE, 8'h00, byte returned to SPI when the FIFO is empty.
REQ-005 SHALL have port clk input 1: system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n input 1: reset, synchronous, active-low.
REQ-007 SHALL have ports for the PCM input: pcm_data input SAMPLE_WIDTH (sample), pcm_channel input 1 (0=L, 1=R; ignored when CHANNELS=1), pcm_valid input 1 (one-cycle strobe, clk domain).
REQ-008 SHALL have port spi_busy input 1: asynchronous byte-request level from the SPI slave.
REQ-009 SHALL have ports for the SPI side: spi_tx_data output 8 (byte to SPI slave), spi_tx_valid output 1 (one-cycle load strobe).
REQ-010 SHALL have port ovf_clr input 1: clears overflow and ovf_count.
REQ-011 SHALL have status ports: fifo_level output $clog2(DEPTH)+1 (bytes stored), overflow output 1 (sticky sample-drop flag), underrun output 1 (one-cycle pulse), ovf_count output 16 (dropped-sample count).

Function
REQ-012 SHALL split each accepted sample into SAMPLE_WIDTH/8 bytes, written LSB first, one byte per clk.
REQ-013 SHALL implement the write FSM with states IDLE and WRITE: IDLE->WRITE on an accepted sample, WRITE->IDLE after the last byte, or WRITE->WRITE if the pending slot is valid.
REQ-014 SHALL accept a sample only if free space >= SAMPLE_WIDTH/8 at acceptance; otherwise drop the whole sample, so no partial sample ever enters the FIFO.
REQ-015 SHALL, on a pcm_valid arriving during WRITE, store it in a one-entry pending slot; if the slot is occupied, drop the sample.
REQ-016 SHALL, when CHANNELS=2, drop any R sample whose preceding L sample was dropped or absent, and any L sample immediately following an L, so the stream stays L/R aligned.
REQ-017 SHALL set overflow the cycle after any drop; overflow stays set until ovf_clr; a drop coinciding with ovf_clr leaves overflow=1.
REQ-018 SHALL pass spi_busy through a 2-flop synchroniser plus an edge register; a request is a synchronised 0->1 transition.
REQ-019 SHALL, on a request with FIFO non-empty, pop one byte; spi_tx_data holds the byte and spi_tx_valid pulses exactly 2 clk after the request cycle (registered RAM read).
REQ-020 SHALL, on a request with FIFO empty, drive spi_tx_data=UNDERRUN_BYTE and pulse spi_tx_valid and underrun 1 clk after the request cycle.
REQ-021 SHALL hold spi_tx_data stable between strobes.
REQ-022 SHALL allow a push and a pop in the same cycle; fifo_level is then unchanged; a pop at empty never occurs; a push at level=DEPTH never occurs.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; fifo_level reaches exactly DEPTH when full.

Reset
REQ-024 SHALL, while rst_n=0, drive spi_tx_data=0, spi_tx_valid=0, fifo_level=0, overflow=0, underrun=0, ovf_count=0, set FSM=IDLE, clear the pending slot, pointers and synchroniser.
REQ-025 SHALL, on reset mid-WRITE, discard the partial sample; FIFO RAM contents need not be cleared.

Configuration
REQ-026 SHALL, with PCM_PACKER_OVF_CNT_EN defined, make ovf_count increment by 1 per dropped sample, saturate at 16'hFFFF, and clear on ovf_clr (a drop in the same cycle gives 1).
REQ-027 SHALL, without PCM_PACKER_OVF_CNT_EN, tie ovf_count to 0 and synthesise no counter logic.

Verification
REQ-028 SHALL test: SAMPLE_WIDTH=24, pcm 24'hA1B2C3 then three spi_busy rises -> tx bytes C3, B2, A1, each valid 2 clk after its synchronised edge.
REQ-029 SHALL test: spi_busy rise on an empty FIFO with UNDERRUN_BYTE=8'h5A -> tx 5A plus underrun pulse 1 clk after the edge.
REQ-030 SHALL test: DEPTH=16, SAMPLE_WIDTH=16, 9 samples without reads -> first 8 stored, 9th dropped, fifo_level=16, overflow=1, ovf_count=1 (macro on) or 0 (macro off).
REQ-031 SHALL test: CHANNELS=2, FIFO with 2 bytes free, L then R -> L stored and R dropped is illegal; L dropped and R dropped, overflow=1, ovf_count=2.
REQ-032 SHALL test: a push and a pop in the same cycle at level=5 -> level stays 5 and data order is preserved.
REQ-033 SHALL test: rst_n low during the 2nd byte of a 32-bit sample -> all outputs 0 and no partial bytes read afterwards.
